layer_seq_ctrl: RTL and testbench
=================================

// Module: layer_seq_ctrl
// PURPOSE
//  Top-level sequencer for the layer-by-layer CNN accelerator. After an initial rest
//  period it runs NUM_LAYERS passes: read weights -> read inputs -> compute -> write output.
//  Each phase is a level start / finish handshake with the weight RAM, input RAM, compute
//  module and output writer. Adds over the earlier single-pass controller: layer counting,
//  optional input-read skip for chained layers, a per-phase watchdog, abort and a done pulse.
// PARAMETERS
//  NUM_LAYERS     5     layers per run, >=1
//  LAYER_W        3     width of layer_idx, 2**LAYER_W >= NUM_LAYERS
//  REST_CYCLES    10    cycles spent in REST before the first layer, >=1
//  CHAIN_LAYERS   1     1: layers 1..N-1 skip RD_I (prior output is in place); 0: RD_I every layer
//  TIMEOUT_CYCLES 1023  max cycles in one handshake phase; 0 disables the watchdog
//  CNT_W          10    width of rest/watchdog counter, holds max(REST_CYCLES, TIMEOUT_CYCLES)
// PORTS
//  clk                  in   1        clock, rising edge
//  rst                  in   1        asynchronous reset, active-high
//  start                in   1        begin a run; sampled in IDLE only
//  abort                in   1        synchronous abort, any state -> IDLE
//  read_weights_finish  in   1        weight RAM load complete
//  read_inputs_finish   in   1        input RAM load complete
//  compute_finish       in   1        compute module finished current layer
//  write_output_finish  in   1        layer output written back
//  start_read_w         out  1        high for every cycle in RD_W
//  start_read_i         out  1        high for every cycle in RD_I
//  start_compute        out  1        high for every cycle in COMP
//  start_write_o        out  1        high for every cycle in WR_O
//  layer_idx            out  LAYER_W  current layer, 0-based
//  busy                 out  1        high in REST..DONE inclusive
//  done                 out  1        one-cycle pulse in DONE
//  error                out  1        high while in ERR
//  state_out            out  3        encoded state, for debug
// BEHAVIOUR
//  - States: IDLE=0 REST=1 RD_W=2 RD_I=3 COMP=4 WR_O=5 DONE=6 ERR=7. All outputs are a
//    registered Moore decode of the state; no combinational input->output path.
//  - Reset: state IDLE; all start_* 0, layer_idx 0, busy 0, done 0, error 0, counters 0.
//  - IDLE: start=1 -> REST with the counter cleared. start is ignored in every other state.
//  - REST: exactly REST_CYCLES cycles, then -> RD_W.
//  - Handshake phase X in {RD_W, RD_I, COMP, WR_O}:
//    - finish_X is sampled only while in X; it is ignored in all other states.
//    - finish_X=1 -> next phase at the next edge. Finish in the first cycle gives a 1-cycle strobe.
//  - Phase order: RD_W -> RD_I -> COMP -> WR_O. When CHAIN_LAYERS=1 and layer_idx>0, RD_W -> COMP.
//  - WR_O finish:
//    - layer_idx==NUM_LAYERS-1: -> DONE.
//    - otherwise: layer_idx+1 and -> RD_W. There is no REST between layers.
//  - DONE: lasts one cycle (done=1, busy=1), then -> IDLE with layer_idx cleared to 0.
//  - Watchdog (TIMEOUT_CYCLES>0):
//    - Counter is cleared on every state change.
//    - TIMEOUT_CYCLES consecutive cycles in one phase without finish -> ERR.
//    - A finish arriving in the same cycle as the timeout wins; no error.
//  - ERR: all start_* 0, error=1, busy=0, layer_idx holds for debug. Left only via abort or rst.
//  - abort=1: -> IDLE at the next edge from any state, clears error and layer_idx.
//    abort has priority over all other transitions.
//  - Reset mid-run: returns to IDLE immediately (asynchronous); start_* drop without any
//    edge. Downstream blocks must treat a start_* drop as cancel.
// TESTING
//  1. NUM_LAYERS=3, CHAIN=1, REST=10, start at edge 0, each finish in the 2nd cycle of its phase
//     -> REST cycles 1-10, RD_W 11-12, RD_I 13-14 (layer 0 only), done=1 in cycle 31, IDLE at 32,
//     layer_idx 0/1/2 at RD_W entry.
//  2. CHAIN_LAYERS=0, same stimulus -> start_read_i strobes in all 3 layers; done in cycle 35.
//  3. compute_finish held high before COMP is entered -> start_compute high for exactly 1 cycle.
//  4. TIMEOUT=16, compute_finish withheld -> ERR after 16 COMP cycles, error=1, start_compute=0;
//     abort=1 -> IDLE next cycle, error=0.
//  5. Finish and timeout in the same cycle -> normal advance, error stays 0.
//  6. rst pulsed mid-RD_I -> start_read_i=0 and state 0 without a clk edge; start pulsed during
//     busy -> ignored, layer_idx unchanged.

Source files
------------

// File: rtl/layer_seq_ctrl.sv
// Layer-by-layer CNN accelerator sequencer: rest period, then per-layer
// weight read / input read / compute / write-back handshakes with watchdog and abort.
module layer_seq_ctrl #(
   parameter int unsigned NUM_LAYERS     = 5,
   parameter int unsigned LAYER_W        = 3,
   parameter int unsigned REST_CYCLES    = 10,
   parameter bit          CHAIN_LAYERS   = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter int unsigned CNT_W          = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               read_weights_finish,
   input  logic               read_inputs_finish,
   input  logic               compute_finish,
   input  logic               write_output_finish,
   output logic               start_read_w,
   output logic               start_read_i,
   output logic               start_compute,
   output logic               start_write_o,
   output logic [LAYER_W-1:0] layer_idx,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [2:0]         state_out
);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StRest = 3'd1,
      StRdW  = 3'd2,
      StRdI  = 3'd3,
      StComp = 3'd4,
      StWrO  = 3'd5,
      StDone = 3'd6,
      StErr  = 3'd7
   } state_e;

   localparam logic [LAYER_W-1:0] LastLayer = LAYER_W'(NUM_LAYERS - 1);
   localparam logic [CNT_W-1:0]   RestLast  = CNT_W'(REST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   WdogLast  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit                 WdogEn    = (TIMEOUT_CYCLES != 0);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LAYER_W-1:0] layer_d;
   logic               in_phase, phase_fin;

   always_comb begin
      state_d   = state_q;
      layer_d   = layer_idx;
      in_phase  = 1'b0;
      phase_fin = 1'b0;
      unique case (state_q)
         StIdle: if (start) state_d = StRest;
         StRest: if (cnt_q == RestLast) state_d = StRdW;
         StRdW: begin
            in_phase  = 1'b1;
            phase_fin = read_weights_finish;
            // Chained layers find their input already in place from the previous write-back.
            if (phase_fin) state_d = (CHAIN_LAYERS && layer_idx != '0) ? StComp : StRdI;
         end
         StRdI: begin
            in_phase  = 1'b1;
            phase_fin = read_inputs_finish;
            if (phase_fin) state_d = StComp;
         end
         StComp: begin
            in_phase  = 1'b1;
            phase_fin = compute_finish;
            if (phase_fin) state_d = StWrO;
         end
         StWrO: begin
            in_phase  = 1'b1;
            phase_fin = write_output_finish;
            if (phase_fin) begin
               if (layer_idx == LastLayer) begin
                  state_d = StDone;
               end else begin
                  state_d = StRdW;
                  layer_d = layer_idx + 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            layer_d = '0;
         end
         StErr:   state_d = StErr;
         default: state_d = StIdle;
      endcase

      // A finish in the timeout cycle wins over the watchdog.
      if (WdogEn && in_phase && !phase_fin && cnt_q == WdogLast) state_d = StErr;

      if (abort) begin
         state_d = StIdle;
         layer_d = '0;
      end

      if (state_d != state_q || !(in_phase || state_q == StRest)) cnt_d = '0;
      else cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         layer_idx     <= '0;
         start_read_w  <= 1'b0;
         start_read_i  <= 1'b0;
         start_compute <= 1'b0;
         start_write_o <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         state_out     <= 3'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         layer_idx     <= layer_d;
         start_read_w  <= (state_d == StRdW);
         start_read_i  <= (state_d == StRdI);
         start_compute <= (state_d == StComp);
         start_write_o <= (state_d == StWrO);
         busy          <= (state_d != StIdle) && (state_d != StErr);
         done          <= (state_d == StDone);
         error         <= (state_d == StErr);
         state_out     <= state_d;
      end
   end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: a chained and an unchained instance, each run against an
// expected per-cycle timeline expanded from randomized phase latencies.
module tb_layer_seq_ctrl;

   localparam int NL   = 3;
   localparam int REST = 10;
   localparam int TO   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst, start, abort;
   logic [3:0] fin [2];
   logic [1:0] srw, sri, scp, swo, busy, done, error;
   logic [1:0] lidx [2];
   logic [2:0] st_o [2];

   int checks = 0;
   int errors = 0;

   layer_seq_ctrl #(
      .NUM_LAYERS(NL), .LAYER_W(2), .REST_CYCLES(REST), .CHAIN_LAYERS(1'b1),
      .TIMEOUT_CYCLES(TO), .CNT_W(5)
   ) dut_chain (
      .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]),
      .read_weights_finish(fin[0][0]), .read_inputs_finish(fin[0][1]),
      .compute_finish(fin[0][2]), .write_output_finish(fin[0][3]),
      .start_read_w(srw[0]), .start_read_i(sri[0]), .start_compute(scp[0]),
      .start_write_o(swo[0]), .layer_idx(lidx[0]), .busy(busy[0]), .done(done[0]),
      .error(error[0]), .state_out(st_o[0])
   );

   layer_seq_ctrl #(
      .NUM_LAYERS(NL), .LAYER_W(2), .REST_CYCLES(REST), .CHAIN_LAYERS(1'b0),
      .TIMEOUT_CYCLES(TO), .CNT_W(5)
   ) dut_flat (
      .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]),
      .read_weights_finish(fin[1][0]), .read_inputs_finish(fin[1][1]),
      .compute_finish(fin[1][2]), .write_output_finish(fin[1][3]),
      .start_read_w(srw[1]), .start_read_i(sri[1]), .start_compute(scp[1]),
      .start_write_o(swo[1]), .layer_idx(lidx[1]), .busy(busy[1]), .done(done[1]),
      .error(error[1]), .state_out(st_o[1])
   );

   typedef struct {
      int         st;
      int         layer;
      logic [3:0] fin;
      logic       strt;
      logic       abrt;
   } step_t;

   step_t tl[$];
   int    fixed_lat, err_phase, stop_at, done_cyc;
   bit    noise, hold_comp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_outs(input int st);
      return {st == 2, st == 3, st == 4, st == 5, st >= 1 && st <= 6, st == 6, st == 7};
   endfunction

   // Finish lines that must not end the current phase (own bit masked off).
   function automatic logic [3:0] nz(input logic [3:0] own);
      logic [3:0] n;
      n = noise ? 4'($urandom) : 4'h0;
      if (hold_comp) n[2] = 1'b1;
      return n & ~own;
   endfunction

   function automatic logic sn();
      return noise ? 1'($urandom) : 1'b0;
   endfunction

   task automatic push(input int st, input int layer, input logic [3:0] f, input logic s);
      step_t e;
      e.st = st; e.layer = layer; e.fin = f; e.strt = s; e.abrt = 1'b0;
      tl.push_back(e);
   endtask

   task automatic build(input int d);
      int         pi, lat;
      bit         stop;
      logic [3:0] own;
      pi   = 0;
      stop = 1'b0;
      tl.delete();
      for (int i = 0; i < REST; i++) push(1, 0, nz(4'h0), sn());
      for (int l = 0; l < NL && !stop; l++) begin
         for (int p = 2; p <= 5 && !stop; p++) begin
            if (d == 0 && l > 0 && p == 3) continue;
            own = 4'b0001 << (p - 2);
            if (pi == err_phase) begin
               for (int i = 0; i < TO; i++) push(p, l, nz(own), sn());
               for (int i = 0; i < 3; i++) push(7, l, nz(4'h0), sn());
               tl[tl.size()-1].abrt = 1'b1;
               stop = 1'b1;
            end else begin
               if (fixed_lat > 0) lat = fixed_lat;
               else lat = ($urandom_range(0, 5) == 0) ? TO : int'($urandom_range(1, 4));
               if (hold_comp && p == 4) lat = 1;
               for (int i = 0; i < lat; i++)
                  push(p, l, (i == lat - 1) ? (nz(own) | own) : nz(own), sn());
               pi++;
            end
         end
      end
      if (!stop) push(6, NL - 1, nz(4'h0), sn());
      push(0, 0, 4'h0, 1'b0);
   endtask

   task automatic add_abort(input int at);
      while (tl.size() > at + 1) void'(tl.pop_back());
      tl[at].abrt = 1'b1;
      push(0, 0, 4'h0, 1'b0);
   endtask

   task automatic exec(input int d);
      @(negedge clk);
      start[d] = 1'b1; abort[d] = 1'b0; fin[d] = 4'h0;
      done_cyc = -1;
      for (int k = 0; k < tl.size(); k++) begin
         @(negedge clk);
         chk($sformatf("d%0d c%0d state", d, k + 1), 32'(st_o[d]), 32'(tl[k].st));
         chk($sformatf("d%0d c%0d outs", d, k + 1),
             32'({srw[d], sri[d], scp[d], swo[d], busy[d], done[d], error[d]}),
             32'(exp_outs(tl[k].st)));
         chk($sformatf("d%0d c%0d layer", d, k + 1), 32'(lidx[d]), 32'(tl[k].layer));
         if (done[d] === 1'b1 && done_cyc < 0) done_cyc = k + 1;
         if (k == stop_at) return;
         start[d] = tl[k].strt; abort[d] = tl[k].abrt; fin[d] = tl[k].fin;
      end
      start[d] = 1'b0; abort[d] = 1'b0; fin[d] = 4'h0;
   endtask

   task automatic set_mode(input int lat, input bit nse, input bit hc, input int ep);
      fixed_lat = lat; noise = nse; hold_comp = hc; err_phase = ep; stop_at = -1;
   endtask

   initial begin
      int idx;
      rst = 2'b11; start = 2'b00; abort = 2'b00; fin[0] = 4'h0; fin[1] = 4'h0;
      set_mode(0, 1'b0, 1'b0, -1);
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d reset state", d), 32'(st_o[d]), 32'd0);
         chk($sformatf("d%0d reset outs", d),
             32'({srw[d], sri[d], scp[d], swo[d], busy[d], done[d], error[d]}), 32'd0);
         chk($sformatf("d%0d reset layer", d), 32'(lidx[d]), 32'd0);
      end
      rst = 2'b00;

      // Fixed 2-cycle phases: done cycle 31 when chained, 35 otherwise.
      set_mode(2, 1'b0, 1'b0, -1);
      build(0); exec(0);
      chk("chain done cycle", 32'(done_cyc), 32'd31);
      build(1); exec(1);
      chk("flat done cycle", 32'(done_cyc), 32'd35);

      // compute_finish held high throughout.
      for (int d = 0; d < 2; d++) begin
         set_mode(0, 1'b1, 1'b1, -1);
         build(d); exec(d);
      end

      // Finish arriving exactly in the timeout cycle.
      for (int d = 0; d < 2; d++) begin
         set_mode(TO, 1'b1, 1'b0, -1);
         build(d); exec(d);
      end

      // Watchdog expiry on a COMP phase, then abort from ERR.
      for (int d = 0; d < 2; d++) begin
         set_mode(0, 1'b1, 1'b0, (d == 0) ? 2 : 2);
         build(d); exec(d);
      end

      // Randomized runs with random watchdog expiries and aborts.
      for (int r = 0; r < 12; r++) begin
         for (int d = 0; d < 2; d++) begin
            set_mode(0, 1'b1, 1'b0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
            build(d);
            if ($urandom_range(0, 3) == 0) add_abort(int'($urandom_range(0, tl.size() - 2)));
            exec(d);
         end
      end

      // Asynchronous reset in the second cycle of RD_I.
      set_mode(3, 1'b0, 1'b0, -1);
      build(1);
      idx = 0;
      while (tl[idx].st != 3) idx++;
      stop_at = idx + 1;
      exec(1);
      #2 rst[1] = 1'b1;
      #1;
      chk("async rst start_read_i", 32'(sri[1]), 32'd0);
      chk("async rst state", 32'(st_o[1]), 32'd0);
      chk("async rst busy", 32'(busy[1]), 32'd0);
      chk("async rst layer", 32'(lidx[1]), 32'd0);
      #1 rst[1] = 1'b0;
      start[1] = 1'b0; abort[1] = 1'b0; fin[1] = 4'h0;
      @(negedge clk);
      chk("post rst idle", 32'(st_o[1]), 32'd0);
      stop_at = -1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
